// File: rtl/ofs_plat_prim_ram_dc_read_arb_if.sv
// Requester-side bundle for the dual-clock RAM read arbiter:
// request valid/ready/address/tag and the shared response path.
interface ofs_plat_prim_ram_dc_read_arb_if #(
    parameter int N_REQ = 4,
    parameter int ADDR_W = 5,
    parameter int TAG_BITS = 4,
    parameter int N_DATA_BITS = 64
);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*TAG_BITS-1:0] req_tag;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ-1:0] rsp_valid;
    logic [N_DATA_BITS-1:0] rsp_data;
    logic [TAG_BITS-1:0] rsp_tag;

    modport master (
        output req_valid, req_addr, req_tag,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_addr, req_tag,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/ofs_plat_prim_ram_dc_read_arb.sv
// Round-robin arbiter for the read port of a dual-clock RAM; tracks each
// read through the fixed RAM latency and routes data + tag back.
module ofs_plat_prim_ram_dc_read_arb #(
    parameter int N_REQ = 4,
    parameter int N_ENTRIES = 32,
    parameter int N_DATA_BITS = 64,
    parameter int N_OUTPUT_REG_STAGES = 0,
    parameter int TAG_BITS = 4,
    localparam int ADDR_W = $clog2(N_ENTRIES)
) (
    input  logic rclk,
    input  logic wreset,
    input  logic ram_rrdy,
    ofs_plat_prim_ram_dc_read_arb_if.slave rd,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [N_DATA_BITS-1:0] ram_rdata,
    output logic busy
);
    localparam int RD_LAT = 1 + N_OUTPUT_REG_STAGES;
    localparam int IDX_W = $clog2(N_REQ);
    localparam int LAST = RD_LAT - 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] gnt_idx;
    logic found;
    logic [N_REQ-1:0] gnt;
    logic [ADDR_W-1:0] gnt_addr;
    logic [ADDR_W-1:0] raddr_q;
    logic [TAG_BITS-1:0] gnt_tag;
    logic [TAG_BITS-1:0] tag_q;
    logic [N_DATA_BITS-1:0] data_q;
    logic rsp_fire;

    logic [RD_LAT-1:0] pv;
    logic [RD_LAT-1:0][N_REQ-1:0] pid;
    logic [RD_LAT-1:0][TAG_BITS-1:0] ptag;

    // Search upward from ptr, wrapping, for the first valid requester
    always_comb begin
        found = 1'b0;
        gnt_idx = '0;
        cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!found && rd.req_valid[cand]) begin
                found = 1'b1;
                gnt_idx = cand;
            end
        end
        if (wreset || !ram_rrdy) begin
            found = 1'b0;
        end
    end

    always_comb begin
        gnt = '0;
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign gnt_addr = rd.req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign gnt_tag = rd.req_tag[gnt_idx*TAG_BITS +: TAG_BITS];

    always_ff @(posedge rclk) begin
        if (wreset) begin
            ptr <= '0;
            raddr_q <= '0;
            data_q <= '0;
            tag_q <= '0;
            pv <= '0;
            pid <= '0;
            ptag <= '0;
        end else begin
            if (found) begin
                ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                raddr_q <= gnt_addr;
            end
            pv[0] <= found;
            pid[0] <= gnt;
            ptag[0] <= gnt_tag;
            for (int s = 1; s < RD_LAT; s++) begin
                pv[s] <= pv[s-1];
                pid[s] <= pid[s-1];
                ptag[s] <= ptag[s-1];
            end
            if (rsp_fire) begin
                data_q <= ram_rdata;
                tag_q <= ptag[LAST];
            end
        end
    end

    assign rsp_fire = pv[LAST] & ~wreset;

    assign rd.req_ready = gnt;
    assign ram_raddr = wreset ? '0 : (found ? gnt_addr : raddr_q);

    // Response data is passed straight through and held once the strobe drops
    assign rd.rsp_valid = rsp_fire ? pid[LAST] : '0;
    assign rd.rsp_data = wreset ? '0 : (rsp_fire ? ram_rdata : data_q);
    assign rd.rsp_tag = wreset ? '0 : (rsp_fire ? ptag[LAST] : tag_q);

    assign busy = ~wreset & (|pv);
endmodule

// File: tb/tb_ofs_plat_prim_ram_dc_read_arb.sv
// Bench for the RAM read arbiter: directed grants with a scoreboard of
// expected responses, using a 3-cycle and a 1-cycle RAM model.
module tb_ofs_plat_prim_ram_dc_read_arb;
    typedef struct {
        int due;
        logic [3:0] id;
        logic [63:0] data;
        logic [3:0] tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rrdy0, rrdy1;
    logic [4:0] raddr0, raddr1;
    logic [63:0] rdata0, rdata1;
    logic busy0, busy1;

    ofs_plat_prim_ram_dc_read_arb_if #(.N_REQ(4), .ADDR_W(5), .TAG_BITS(4), .N_DATA_BITS(64)) v0 ();
    ofs_plat_prim_ram_dc_read_arb_if #(.N_REQ(4), .ADDR_W(5), .TAG_BITS(4), .N_DATA_BITS(64)) v1 ();

    ofs_plat_prim_ram_dc_read_arb #(
        .N_REQ(4), .N_ENTRIES(32), .N_DATA_BITS(64),
        .N_OUTPUT_REG_STAGES(2), .TAG_BITS(4)
    ) u0 (
        .rclk(clk), .wreset(rst), .ram_rrdy(rrdy0), .rd(v0.slave),
        .ram_raddr(raddr0), .ram_rdata(rdata0), .busy(busy0)
    );

    ofs_plat_prim_ram_dc_read_arb #(
        .N_REQ(4), .N_ENTRIES(32), .N_DATA_BITS(64),
        .N_OUTPUT_REG_STAGES(0), .TAG_BITS(4)
    ) u1 (
        .rclk(clk), .wreset(rst), .ram_rrdy(rrdy1), .rd(v1.slave),
        .ram_raddr(raddr1), .ram_rdata(rdata1), .busy(busy1)
    );

    logic [63:0] mem0 [32];
    logic [63:0] mem1 [32];
    logic [63:0] r0a, r0b, r0c, r1;

    always @(posedge clk) begin
        r0a <= mem0[raddr0];
        r0b <= r0a;
        r0c <= r0b;
        r1 <= mem1[raddr1];
    end
    assign rdata0 = r0c;
    assign rdata1 = r1;

    logic [4:0] a0 [4];
    logic [3:0] t0 [4];
    logic [4:0] a1;
    logic [3:0] t1;

    always_comb begin
        v0.req_addr = '0;
        v0.req_tag = '0;
        for (int i = 0; i < 4; i++) begin
            v0.req_addr[i*5 +: 5] = a0[i];
            v0.req_tag[i*4 +: 4] = t0[i];
        end
    end
    assign v1.req_addr = {4{a1}};
    assign v1.req_tag = {4{t1}};

    for (genvar i = 0; i < 4; i++) begin : g_hold
        assert property (@(posedge clk) disable iff (rst)
            (v0.req_valid[i] && !v0.req_ready[i]) |=>
            (!v0.req_valid[i] ||
             ($stable(v0.req_addr[i*5 +: 5]) && $stable(v0.req_tag[i*4 +: 4]))))
        else $error("FAIL hold%0d: address/tag changed while waiting for grant", i);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;
    bit chk_rdy = 0, chk_rst = 0, chk_idle = 0, chk_end = 0;
    logic [3:0] e_rdy = '0;

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic rsp(input int d, input logic [3:0] rv,
                       input logic [63:0] rdat, input logic [3:0] rtag);
        exp_t e;
        bit have;
        have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (have) e = (d == 0) ? q0[0] : q1[0];
        if (rv != 0) begin
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL rsp%0d_unexpected: got id=%b tag=%h data=%h, required none (cycle %0d)",
                         d, rv, rtag, rdat, cyc);
            end else begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                if (e.due != cyc || e.id !== rv || e.data !== rdat || e.tag !== rtag) begin
                    errors++;
                    $display("FAIL rsp%0d: got cycle=%0d id=%b tag=%h data=%h, required cycle=%0d id=%b tag=%h data=%h",
                             d, cyc, rv, rtag, rdat, e.due, e.id, e.tag, e.data);
                end
            end
        end else if (have && e.due < cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp%0d_missing: got none by cycle %0d, required id=%b tag=%h at cycle %0d",
                     d, cyc, e.id, e.tag, e.due);
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (chk_rst) begin
            cmp("rst_ready", 64'(v0.req_ready), 64'h0);
            cmp("rst_rsp_valid", 64'(v0.rsp_valid), 64'h0);
            cmp("rst_busy", 64'(busy0), 64'h0);
            cmp("rst_raddr", 64'(raddr0), 64'h0);
            cmp("rst_rsp_data", v0.rsp_data, 64'h0);
            cmp("rst_rsp_tag", 64'(v0.rsp_tag), 64'h0);
        end else if (chk_rdy) begin
            cmp("grant", 64'(v0.req_ready), 64'(e_rdy));
        end
        if (chk_idle) cmp("busy_after_reset", 64'(busy0), 64'h0);
        rsp(0, v0.rsp_valid, v0.rsp_data, v0.rsp_tag);
        rsp(1, v1.rsp_valid, v1.rsp_data, v1.rsp_tag);
        if (chk_end) begin
            cmp("q0_drained", 64'(q0.size()), 64'h0);
            cmp("q1_drained", 64'(q1.size()), 64'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on u0: valids v, hand-computed grant g
    task automatic step(input logic [3:0] v, input logic [3:0] g, input bit push);
        v0.req_valid = v;
        e_rdy = g;
        chk_rdy = 1'b1;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (g[i]) q0.push_back('{cyc + 3, g, mem0[a0[i]], t0[i]});
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        rrdy0 = 1'b0;
        rrdy1 = 1'b0;
        v0.req_valid = '0;
        v1.req_valid = '0;
        a1 = '0;
        t1 = '0;
        for (int i = 0; i < 4; i++) begin
            a0[i] = 5'(i + 1);
            t0[i] = 4'(i + 1);
        end
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 64'hA0 + 64'(i);
            mem1[i] = {$urandom, $urandom};
        end

        tick();
        chk_rst = 1'b1;
        tick();
        rrdy0 = 1'b1;
        v0.req_valid = 4'hF;
        tick();
        chk_rst = 1'b0;
        rst = 1'b0;

        // Held off until RAM ready, then requester 0 wins immediately
        rrdy0 = 1'b0;
        repeat (10) step(4'hF, 4'h0, 0);
        rrdy0 = 1'b1;
        step(4'hF, 4'b0001, 1);
        repeat (5) step(4'h0, 4'h0, 0);

        // Single read on requester 2, addr 5, tag 3
        a0[2] = 5'd5;
        t0[2] = 4'd3;
        step(4'b0100, 4'b0100, 1);
        repeat (5) step(4'h0, 4'h0, 0);

        // Two reads in flight, then reset with a request pending
        step(4'b1000, 4'b1000, 0);
        step(4'b0001, 4'b0001, 0);
        rst = 1'b1;
        chk_rst = 1'b1;
        step(4'b0010, 4'h0, 0);
        rst = 1'b0;
        chk_rst = 1'b0;
        chk_idle = 1'b1;
        step(4'h0, 4'h0, 0);
        chk_idle = 1'b0;

        // All four contending: rotation restarts at 0
        for (int i = 0; i < 4; i++) begin
            a0[i] = 5'(8 + i);
            t0[i] = 4'(5 + i);
        end
        for (int n = 0; n < 8; n++) step(4'hF, 4'(1 << (n % 4)), 1);
        repeat (5) step(4'h0, 4'h0, 0);

        // Requester 3 alone, then requester 1 joins
        step(4'b1000, 4'b1000, 1);
        step(4'b1010, 4'b0010, 1);
        step(4'b1010, 4'b1000, 1);
        step(4'b1010, 4'b0010, 1);
        step(4'b1010, 4'b1000, 1);
        repeat (5) step(4'h0, 4'h0, 0);
        chk_rdy = 1'b0;

        // Back-to-back sweep on the single-cycle RAM
        rrdy1 = 1'b1;
        for (int n = 0; n < 32; n++) begin
            a1 = 5'(n);
            t1 = 4'(n);
            v1.req_valid = 4'b0001;
            q1.push_back('{cyc + 1, 4'b0001, mem1[n], 4'(n)});
            tick();
        end
        v1.req_valid = '0;
        repeat (5) tick();

        chk_end = 1'b1;
        tick();
        chk_end = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
